icestick_led_sampler: RTL and testbench
=======================================

# icestick_led_sampler

Downstream consumer of the free-running 4-bit counter on the icestick board. It periodically invokes the counter's value method using the RDY/EN/RV protocol. It latches the returned value and drives it onto the four red LEDs, PWM-dimmed. The centre green LED toggles each time the sampled value wraps, so counter activity is visible at human speed despite the 12 MHz clock.

## Interface
Parameters:
- PRESCALE, default 3000000 — sample period in CLK cycles; legal range ≥ 4; prescaler width is clog2(PRESCALE).
- BRIGHT, default 16 — PWM duty in sixteenths, 0..16; 0 = LEDs off, 16 = always on.

Ports:
- CLK  in  1  clock (12 MHz on board)
- RST_N  in  1  reset, synchronous, active-low
- count_RDY  in  1  upstream value method ready
- count_EN  out  1  upstream value method enable; one-cycle pulse
- count_RV  in  4  upstream value method return value; valid while count_RDY
- led  out  4  red LEDs D1..D4, bit i = sampled bit i gated by PWM
- led_wrap  out  1  green LED D5, toggles on each detected wrap, not dimmed

## Operation
Prescaler:
- Counts 0..PRESCALE-1 and wraps to 0.
- Emits `tick` during the cycle in which it equals PRESCALE-1.

FSM, state register, reset state IDLE:
- IDLE: on `tick` → REQ; otherwise stay.
- REQ: count_EN = count_RDY (combinational AND with state==REQ).
  - If count_RDY: sample <= count_RV, → UPDATE.
  - If not count_RDY: stay in REQ indefinitely.
- UPDATE:
  - led_val <= sample.
  - If sample < prev (unsigned, strict): wrap_q <= ~wrap_q.
  - prev <= sample.
  - → IDLE.

Boundary rules:
- A `tick` seen while in REQ or UPDATE is dropped; no queuing and no catch-up request.
- The prescaler never stalls.
- Equal consecutive samples do not toggle; 15→0 toggles; 15→14 toggles (any strict decrease counts as a wrap).

PWM:
- pwm_cnt is a 4-bit free-running counter from reset, wrapping 15→0.
- led[i] = led_val[i] & (pwm_cnt < BRIGHT); the comparison is 5-bit, so BRIGHT=16 is always true.
- led_wrap = wrap_q.

Reset (RST_N low at a CLK edge), effective from the next cycle regardless of state:
- State IDLE; prescaler, pwm_cnt, sample, prev, led_val and wrap_q all 0.
- Outputs led=0, led_wrap=0, count_EN=0.
- A request in progress is abandoned, with no partial capture.

## Timing
- Cycle 0 is the first cycle with RST_N high; the prescaler is 0 in cycle 0.
- First `tick` in cycle PRESCALE-1; REQ in cycle PRESCALE.
- count_EN is high in cycle PRESCALE if count_RDY=1.
- UPDATE in cycle PRESCALE+1; new led/led_wrap visible from cycle PRESCALE+2.
- Request-to-display latency is 2 cycles after the RDY&EN cycle.
- count_EN is never high for two consecutive cycles.
- count_EN is never high while count_RDY is low.
- count_EN is never high outside REQ.
- Steady state with RDY always 1: exactly one EN pulse per PRESCALE cycles.

## Test plan
1. Reset: RST_N low 5 cycles with count_RDY=1, count_RV=4'hA → led=0, led_wrap=0, count_EN=0 throughout and in the first cycle after release.
2. Basic sample: PRESCALE=8, BRIGHT=16, RDY=1, RV=4'd5 constant.
   - Required: count_EN high only in cycles 8, 16, 24, ….
   - Required: led=4'b0101 from cycle 10; led_wrap stays 0.
3. RDY stall: PRESCALE=8; RDY=0 from cycle 0 to cycle 29, RV=4'd9.
   - Required: count_EN=0 through cycle 29; ticks at cycles 15 and 23 are dropped.
   - Required: RDY=1 at cycle 30 → count_EN high in cycle 30 only, led=4'd9 from cycle 32.
   - Required: next EN is at the next post-IDLE tick, cycle 40.
4. Wrap detection: PRESCALE=8, RV driven to 14, 2, 3, 3, 0 on successive samples.
   - Required: led_wrap 0→1 after the 2, unchanged after both 3s, 1→0 after the 0.
5. PWM: led_val=4'hF.
   - BRIGHT=4 → each led bit high exactly 4 of every 16 cycles, namely while pwm_cnt is 0..3.
   - BRIGHT=0 → led=0 always; BRIGHT=16 → led=4'hF always.
6. Reset mid-request: RDY=0, enter REQ, assert RST_N low for 1 cycle, then raise RDY=1.
   - Required: no capture; led=0; count_EN=0 until the cycle PRESCALE after release, measured from the new cycle 0.

Source files
------------

// File: rtl/icestick_led_sampler.sv
// Periodic sampler of the icestick free-running counter over the RDY/EN/RV method protocol.
// It drives the sampled value onto the PWM-dimmed red LEDs and toggles the green LED on each wrap.
module icestick_led_sampler #(
    parameter int PRESCALE = 3000000,
    parameter int BRIGHT   = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       count_RDY,
    output logic       count_EN,
    input  logic [3:0] count_RV,
    output logic [3:0] led,
    output logic       led_wrap
);

    localparam int             PW       = $clog2(PRESCALE);
    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [4:0]     BRIGHT_L = 5'(BRIGHT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        UPDATE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    pwm_q, pwm_d;
    logic [3:0]    sample_q, sample_d;
    logic [3:0]    prev_q, prev_d;
    logic [3:0]    led_val_q, led_val_d;
    logic          wrap_q, wrap_d;
    logic          tick;
    logic          pwm_on;

    // NOTE: every signal gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        prev_d    = prev_q;
        led_val_d = led_val_q;
        wrap_d    = wrap_q;
        count_EN  = 1'b0;

        tick    = (presc_q == PRE_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
        pwm_d   = pwm_q + 4'd1;

        // A tick arriving outside IDLE is simply dropped, so requests never queue up.
        unique case (state_q)
            IDLE: begin
                if (tick) state_d = REQ;
            end
            REQ: begin
                count_EN = count_RDY;
                if (count_RDY) begin
                    sample_d = count_RV;
                    state_d  = UPDATE;
                end
            end
            UPDATE: begin
                led_val_d = sample_q;
                if (sample_q < prev_q) wrap_d = ~wrap_q;
                prev_d  = sample_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            pwm_q     <= '0;
            sample_q  <= '0;
            prev_q    <= '0;
            led_val_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            pwm_q     <= pwm_d;
            sample_q  <= sample_d;
            prev_q    <= prev_d;
            led_val_q <= led_val_d;
            wrap_q    <= wrap_d;
        end
    end

    // The compare is 5 bits wide, so BRIGHT=16 keeps the LEDs permanently on.
    assign pwm_on   = ({1'b0, pwm_q} < BRIGHT_L);
    assign led      = led_val_q & {4{pwm_on}};
    assign led_wrap = wrap_q;

endmodule

// File: tb/tb_icestick_led_sampler.sv
// Directed bench for icestick_led_sampler: PRESCALE=8 with three BRIGHT settings sharing one stimulus.
// Cycle n counts from the first cycle after the final reset edge; checks run 2 time units after each edge.
module tb_icestick_led_sampler;

    logic       CLK;
    logic       RST_N;
    logic       count_RDY;
    logic [3:0] count_RV;

    logic       en16, en4, en0;
    logic [3:0] led16, led4, led0;
    logic       wrap16, wrap4, wrap0;

    int n_vec;
    int n_bad;
    int cyc;

    icestick_led_sampler #(.PRESCALE(8), .BRIGHT(16)) u_b16 (
        .CLK(CLK), .RST_N(RST_N), .count_RDY(count_RDY), .count_EN(en16),
        .count_RV(count_RV), .led(led16), .led_wrap(wrap16)
    );

    icestick_led_sampler #(.PRESCALE(8), .BRIGHT(4)) u_b4 (
        .CLK(CLK), .RST_N(RST_N), .count_RDY(count_RDY), .count_EN(en4),
        .count_RV(count_RV), .led(led4), .led_wrap(wrap4)
    );

    icestick_led_sampler #(.PRESCALE(8), .BRIGHT(0)) u_b0 (
        .CLK(CLK), .RST_N(RST_N), .count_RDY(count_RDY), .count_EN(en0),
        .count_RV(count_RV), .led(led0), .led_wrap(wrap0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        RST_N = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        RST_N     = 1'b0;
        count_RDY = 1'b1;
        count_RV  = 4'hA;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #2;
            if ({en16, led16, wrap16} !== 6'b0) begin
                $display("FAIL reset_hold[%0d]: en=%b led=%h wrap=%b, want all 0", i, en16, led16, wrap16);
                n_bad++;
            end
            n_vec++;
        end
        RST_N = 1'b1;
        cyc   = 0;
        #1;
        if ({en16, led16, wrap16} !== 6'b0) begin
            $display("FAIL reset_release: en=%b led=%h wrap=%b, want all 0", en16, led16, wrap16);
            n_bad++;
        end
        n_vec++;
    endtask

    task automatic test_basic();
        logic       exp_en;
        logic [3:0] exp_led;
        count_RDY = 1'b1;
        count_RV  = 4'd5;
        do_reset(1);
        while (cyc <= 40) begin
            #1;
            exp_en  = (cyc > 0) && (cyc % 8 == 0);
            exp_led = (cyc >= 10) ? 4'b0101 : 4'b0000;
            if (en16 !== exp_en) begin
                $display("FAIL basic_en cyc=%0d: got %b, want %b", cyc, en16, exp_en);
                n_bad++;
            end
            n_vec++;
            if (led16 !== exp_led || wrap16 !== 1'b0) begin
                $display("FAIL basic_led cyc=%0d: got led=%h wrap=%b, want led=%h wrap=0", cyc, led16, wrap16, exp_led);
                n_bad++;
            end
            n_vec++;
            step();
        end
    endtask

    task automatic test_rdy_stall();
        logic       exp_en;
        logic [3:0] exp_led;
        count_RDY = 1'b0;
        count_RV  = 4'd9;
        do_reset(1);
        while (cyc <= 45) begin
            count_RDY = (cyc >= 30);
            #1;
            exp_en  = (cyc == 30) || (cyc == 40);
            exp_led = (cyc >= 32) ? 4'd9 : 4'd0;
            if (en16 !== exp_en) begin
                $display("FAIL stall_en cyc=%0d: got %b, want %b", cyc, en16, exp_en);
                n_bad++;
            end
            n_vec++;
            if (led16 !== exp_led) begin
                $display("FAIL stall_led cyc=%0d: got %h, want %h", cyc, led16, exp_led);
                n_bad++;
            end
            n_vec++;
            step();
        end
    endtask

    task automatic test_wrap();
        logic [3:0] vals [5];
        logic       exp_wrap;
        logic [3:0] exp_led;
        vals[0] = 4'd14; vals[1] = 4'd2; vals[2] = 4'd3; vals[3] = 4'd3; vals[4] = 4'd0;
        count_RDY = 1'b1;
        count_RV  = 4'd0;
        do_reset(1);
        while (cyc <= 47) begin
            if (cyc >= 8) count_RV = vals[cyc / 8 - 1];
            #1;
            exp_wrap = (cyc >= 18) && (cyc < 42);
            exp_led  = (cyc >= 10) ? vals[(cyc - 10) / 8] : 4'd0;
            if (wrap16 !== exp_wrap) begin
                $display("FAIL wrap cyc=%0d: got %b, want %b", cyc, wrap16, exp_wrap);
                n_bad++;
            end
            n_vec++;
            if (led16 !== exp_led) begin
                $display("FAIL wrap_led cyc=%0d: got %h, want %h", cyc, led16, exp_led);
                n_bad++;
            end
            n_vec++;
            step();
        end
    endtask

    task automatic test_pwm();
        logic [3:0] exp4, exp16;
        count_RDY = 1'b1;
        count_RV  = 4'hF;
        do_reset(1);
        while (cyc <= 41) begin
            #1;
            exp16 = (cyc >= 10) ? 4'hF : 4'h0;
            exp4  = (cyc >= 10 && (cyc % 16) < 4) ? 4'hF : 4'h0;
            if (led4 !== exp4) begin
                $display("FAIL pwm_b4 cyc=%0d: got %h, want %h", cyc, led4, exp4);
                n_bad++;
            end
            n_vec++;
            if (led0 !== 4'h0) begin
                $display("FAIL pwm_b0 cyc=%0d: got %h, want 0", cyc, led0);
                n_bad++;
            end
            n_vec++;
            if (led16 !== exp16) begin
                $display("FAIL pwm_b16 cyc=%0d: got %h, want %h", cyc, led16, exp16);
                n_bad++;
            end
            n_vec++;
            step();
        end
    endtask

    task automatic test_reset_mid_request();
        logic       exp_en;
        logic [3:0] exp_led;
        count_RDY = 1'b0;
        count_RV  = 4'd7;
        do_reset(1);
        while (cyc <= 9) begin
            #1;
            if (en16 !== 1'b0 || led16 !== 4'd0) begin
                $display("FAIL midreq_pre cyc=%0d: got en=%b led=%h, want en=0 led=0", cyc, en16, led16);
                n_bad++;
            end
            n_vec++;
            if (cyc < 9) step();
            else break;
        end
        do_reset(1);
        count_RDY = 1'b1;
        while (cyc <= 12) begin
            #1;
            exp_en  = (cyc == 8);
            exp_led = (cyc >= 10) ? 4'd7 : 4'd0;
            if (en16 !== exp_en) begin
                $display("FAIL midreq_en cyc=%0d: got %b, want %b", cyc, en16, exp_en);
                n_bad++;
            end
            n_vec++;
            if (led16 !== exp_led) begin
                $display("FAIL midreq_led cyc=%0d: got %h, want %h", cyc, led16, exp_led);
                n_bad++;
            end
            n_vec++;
            step();
        end
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        cyc       = 0;
        RST_N     = 1'b0;
        count_RDY = 1'b0;
        count_RV  = 4'd0;
        test_reset();
        test_basic();
        test_rdy_stall();
        test_wrap();
        test_pwm();
        test_reset_mid_request();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
